// File: rtl/sng_stream_scheduler.sv
// sng_stream_scheduler: round-robin arbiter sharing one 16-slot unary-weighted
// stochastic bitstream generator among NREQ valid/ready requesters.
module sng_stream_scheduler #(
  parameter int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic              i_clk_sng,
  input  logic              i_rst_sng,
  input  logic [NREQ-1:0]   i_req_valid,
  input  logic [4*NREQ-1:0] i_req_data,
  output logic [NREQ-1:0]   o_req_ready,
  output logic              o_bit,
  output logic              o_bit_valid,
  input  logic              i_bit_ready,
  output logic              o_bit_last,
  output logic [ID_W-1:0]   o_bit_id,
  input  logic              i_abort,
  output logic              o_done,
  output logic [ID_W-1:0]   o_done_id,
  output logic              o_done_aborted,
  output logic [4:0]        o_ones_cnt,
  output logic              o_busy
);
  typedef enum logic [1:0] {IDLE = 2'b00, GEN = 2'b01, DONE = 2'b10} state_e;
  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_q, rr_d, id_q, id_d, gnt_id, idx;
  logic [3:0]      k_q, k_d, x_q, x_d;
  logic [4:0]      ones_q, ones_d;
  logic            ab_q, ab_d, init_q, gnt_found, grant, bit_w, is_gen;
  logic [1:0]      sel;
  always_ff @(posedge i_clk_sng or posedge i_rst_sng) begin
    if (i_rst_sng) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      k_q     <= '0;
      x_q     <= '0;
      ones_q  <= '0;
      ab_q    <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      k_q     <= k_d;
      x_q     <= x_d;
      ones_q  <= ones_d;
      ab_q    <= ab_d;
      init_q  <= 1'b1;
    end
  end
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ID_W'((int'(rr_q) + i) % NREQ);
      if (!gnt_found && i_req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx;
      end
    end
  end
  // init_q keeps every output at 0 during the first cycle after reset
  assign grant  = init_q && state_q == IDLE && gnt_found;
  assign is_gen = state_q == GEN;
  // slot k picks operand bit weighted 8/4/2/1 times over slots 0..14
  assign sel    = !k_q[0] ? 2'd3 : k_q[1:0] == 2'b01 ? 2'd2 : k_q[2:0] == 3'b011 ? 2'd1 : 2'd0;
  assign bit_w  = is_gen && k_q != 4'd15 && x_q[sel];
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    k_d     = k_q;
    x_d     = x_q;
    ones_d  = ones_q;
    ab_d    = ab_q;
    case (state_q)
      IDLE: if (grant) begin
        state_d = GEN;
        x_d     = i_req_data[gnt_id*4 +: 4];
        id_d    = gnt_id;
        k_d     = '0;
        ones_d  = '0;
        ab_d    = 1'b0;
        rr_d    = gnt_id == ID_W'(NREQ - 1) ? '0 : gnt_id + 1'b1;
      end
      GEN: if (i_abort) begin
        state_d = DONE;
        ab_d    = 1'b1;
      end else if (i_bit_ready) begin
        k_d     = k_q + 4'd1;
        ones_d  = ones_q + 5'(bit_w);
        state_d = k_q == 4'd15 ? DONE : GEN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign o_req_ready    = grant ? {{(NREQ-1){1'b0}}, 1'b1} << gnt_id : '0;
  assign o_bit          = bit_w;
  assign o_bit_valid    = is_gen && !i_abort;
  assign o_bit_last     = is_gen && k_q == 4'd15;
  assign o_bit_id       = is_gen ? id_q : '0;
  assign o_done         = state_q == DONE;
  assign o_done_id      = o_done ? id_q : '0;
  assign o_done_aborted = o_done && ab_q;
  assign o_ones_cnt     = o_done ? ones_q : '0;
  assign o_busy         = state_q != IDLE;
endmodule
